if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end: owns the PC, issues requests to instruction memory
//  over a req/gnt/rvalid handshake, and presents {inst_out, pc_out} to the IF/ID register.
//  Honours the pipeline stall, and applies branch/jump redirects that flush in-flight fetches.
//  One-entry output buffer and at most one outstanding imem request.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  NOP_INST   32'h0000_0000  instruction driven when inst_valid=0 (bubble; matches IF/ID flush value)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-high
//  stall         in   1   same signal as IF/ID write-hold: 1 = IF/ID holds, 0 = IF/ID captures this edge
//  redirect      in   1   branch/jump taken; load redirect_pc, flush buffer and in-flight fetch
//  redirect_pc   in   32  new PC; bits[1:0] forced to 0
//  imem_req      out  1   request valid
//  imem_addr     out  32  word-aligned fetch address (= pc_q while imem_req)
//  imem_gnt      in   1   request accepted this cycle (only meaningful when imem_req=1)
//  imem_rvalid   in   1   read data valid; >=1 cycle after the gnt cycle
//  imem_rdata    in   32  instruction word
//  inst_out      out  32  buffered instruction, NOP_INST when inst_valid=0
//  pc_out        out  32  address of inst_out (0 when inst_valid=0)
//  inst_valid    out  1   buffer holds a live instruction
// BEHAVIOUR
//  Reset: state=IDLE, pc_q=RESET_PC, inst_valid=0, inst_out=NOP_INST, pc_out=0, imem_req=0.
//  consume = inst_valid & ~stall (IF/ID takes the buffer at this edge). room = ~inst_valid | consume.
//  FSM (registered state):
//   IDLE : imem_req=0; next cycle -> REQ. imem_rvalid ignored.
//   REQ  : imem_req=room & ~redirect, imem_addr=pc_q. If req & gnt -> WAIT.
//          If ~room, stay in REQ with imem_req=0 (no request may be issued without buffer room).
//   WAIT : imem_req=0. On imem_rvalid: inst_out<=rdata, pc_out<=pc_q, inst_valid<=1,
//          pc_q<=pc_q+4 (mod 2^32, wraps 0xFFFF_FFFC->0), -> REQ.
//   DROP : imem_req=0; waiting for a stale response. On imem_rvalid: discard data -> REQ.
//  Buffer: on consume with no new fill, inst_valid<=0, inst_out<=NOP_INST, pc_out<=0.
//   Fill and consume on the same edge: the fill wins (new data loaded, inst_valid stays 1).
//   stall=1: buffer, pc_out, inst_out held bit-exact; a pending response still completes
//   into the buffer only if the buffer is empty (guaranteed by the room rule).
//  Redirect (priority over stall and over every FSM event):
//   pc_q<=redirect_pc & ~3; inst_valid<=0, inst_out<=NOP_INST, pc_out<=0 at that edge.
//   From REQ (granted or not): no request is issued in the redirect cycle (imem_req=0) -> REQ.
//   From WAIT without rvalid -> DROP. From WAIT with rvalid same cycle: data discarded -> REQ.
//   From DROP -> stays DROP (still one stale response pending). From IDLE -> IDLE.
//  Redirect concurrent with reset: reset wins.
//  Outstanding count is never >1; imem_rvalid in REQ/IDLE is a protocol error (ignored).
//  Latency: 1-cycle memory, no stall -> first inst_valid 3 cycles after reset release
//   (IDLE, REQ+gnt, WAIT+rvalid); steady state 1 instruction per 2 cycles.
//  Reset mid-WAIT/DROP: all state cleared; a late rvalid arriving in IDLE is ignored.
// TESTING
//  1 Reset release, imem 1-cycle latency, stall=0 -> addrs 0x0,0x4,0x8 requested in order;
//    inst_out/pc_out pairs match memory image; inst_valid first high 3 cycles after reset.
//  2 stall=1 for 5 cycles while inst_valid=1 -> inst_out/pc_out stable, imem_req=0 throughout;
//    on release the next fetch is pc_out+4; no instruction lost or duplicated.
//  3 redirect to 0x0000_0102 during WAIT (latency 3) -> stale rdata discarded (DROP),
//    next imem_addr=0x0000_0100, inst_valid=0 until its response.
//  4 redirect in the same cycle as imem_rvalid -> that rdata never appears on inst_out;
//    redirect together with stall=1 -> buffer still flushed to NOP_INST.
//  5 pc_q=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000.
//  6 reset asserted mid-WAIT, late imem_rvalid one cycle later -> ignored; refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory req/gnt/rvalid bus between fetch unit and imem.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and imem fetcher feeding a one-entry buffer to IF/ID, with stall and redirect flush.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  if_fetch_unit_if.master          imem,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic                     inst_valid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_out_q, inst_out_d, pc_out_q, pc_out_d;
  logic        inst_valid_q, inst_valid_d;
  logic        consume, room, fill;
  always_comb begin
    consume      = inst_valid_q & ~stall;
    room         = ~inst_valid_q | consume;
    imem.req     = (state_q == REQ) & room & ~redirect;
    imem.addr    = pc_q;
    fill         = (state_q == WAIT) & imem.rvalid & ~redirect;
    state_d      = state_q;
    case (state_q)
      IDLE:    state_d = redirect ? IDLE : REQ;
      REQ:     state_d = (imem.req & imem.gnt) ? WAIT : REQ;
      WAIT:    state_d = imem.rvalid ? REQ : (redirect ? DROP : WAIT);
      DROP:    state_d = (imem.rvalid & ~redirect) ? REQ : DROP;
      default: state_d = IDLE;
    endcase
    // a redirect flushes the buffer regardless of stall; a fill beats a same-edge consume
    pc_d         = redirect ? (redirect_pc & ~32'd3) : (fill ? pc_q + 32'd4 : pc_q);
    inst_valid_d = ~redirect & (fill | (inst_valid_q & ~consume));
    inst_out_d   = redirect ? NOP_INST : (fill ? imem.rdata : (consume ? NOP_INST : inst_out_q));
    pc_out_d     = redirect ? 32'd0 : (fill ? pc_q : (consume ? 32'd0 : pc_out_q));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_out_q   <= NOP_INST;
      pc_out_q     <= 32'd0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      pc_out_q     <= pc_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end
  assign inst_out   = inst_out_q;
  assign pc_out     = pc_out_q;
  assign inst_valid = inst_valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch order, stall hold, redirect flush, PC wrap and reset recovery.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] inst_out, pc_out;
  logic        inst_valid;
  int          nv = 0, nf = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] pend = 32'd0;
  if_fetch_unit_if bus();
  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(bus), .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid)
  );
  always #5 clk = ~clk;
  // memory: always grants, answers lat cycles after the grant cycle, data = addr ^ C0DE0000
  assign bus.gnt    = 1'b1;
  assign bus.rvalid = (cnt == 1);
  assign bus.rdata  = pend ^ 32'hC0DE_0000;
  always @(posedge clk)
    if (bus.req && bus.gnt) begin
      pend <= bus.addr;
      cnt  <= lat;
    end else if (cnt != 0) cnt <= cnt - 1;
  task cyc;
    @(posedge clk);
    #2;
  endtask
  task do_reset;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    repeat (4) cyc;
    reset = 1'b0;
  endtask
  task test_reset;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    repeat (4) cyc;
    #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== 65'd0) begin nf++; $display("FAIL reset_buf got %b/%h/%h want 0/00000000/00000000", inst_valid, pc_out, inst_out); end
    nv++; if (bus.req !== 1'b0) begin nf++; $display("FAIL reset_req got %b want 0", bus.req); end
    reset = 1'b0;
  endtask
  task test_fetch;
    #1;
    nv++; if (bus.req !== 1'b0) begin nf++; $display("FAIL fetch_idle_req got %b want 0", bus.req); end
    cyc; #1;
    nv++; if ({bus.req, bus.addr} !== {1'b1, 32'h0}) begin nf++; $display("FAIL fetch_req0 got %b/%h want 1/00000000", bus.req, bus.addr); end
    cyc; #1;
    nv++; if ({bus.req, inst_valid} !== 2'b00) begin nf++; $display("FAIL fetch_wait0 got req=%b valid=%b want 0/0", bus.req, inst_valid); end
    for (int k = 0; k < 3; k++) begin
      cyc; #1;
      nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'(4 * k), 32'hC0DE_0000 | 32'(4 * k)})
        begin nf++; $display("FAIL fetch_buf%0d got %b/%h/%h want 1/%h/%h", k, inst_valid, pc_out, inst_out, 32'(4 * k), 32'hC0DE_0000 | 32'(4 * k)); end
      nv++; if ({bus.req, bus.addr} !== {1'b1, 32'(4 * k + 4)}) begin nf++; $display("FAIL fetch_req%0d got %b/%h want 1/%h", k + 1, bus.req, bus.addr, 32'(4 * k + 4)); end
      cyc; #1;
      nv++; if ({bus.req, inst_valid} !== 2'b00) begin nf++; $display("FAIL fetch_drain%0d got req=%b valid=%b want 0/0", k, bus.req, inst_valid); end
    end
  endtask
  task test_stall;
    cyc;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'hC, 32'hC0DE_000C}) begin nf++; $display("FAIL stall_buf%0d got %b/%h/%h want 1/0000000c/c0de000c", i, inst_valid, pc_out, inst_out); end
      nv++; if (bus.req !== 1'b0) begin nf++; $display("FAIL stall_req%0d got %b want 0", i, bus.req); end
      cyc;
    end
    stall = 1'b0; #1;
    nv++; if ({bus.req, bus.addr} !== {1'b1, 32'h10}) begin nf++; $display("FAIL stall_release_req got %b/%h want 1/00000010", bus.req, bus.addr); end
    cyc; #1;
    nv++; if (inst_valid !== 1'b0) begin nf++; $display("FAIL stall_consumed got %b want 0", inst_valid); end
    cyc; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h10, 32'hC0DE_0010}) begin nf++; $display("FAIL stall_next_buf got %b/%h/%h want 1/00000010/c0de0010", inst_valid, pc_out, inst_out); end
  endtask
  task test_redirect_wait;
    lat = 3;
    do_reset;
    cyc; cyc;
    redirect = 1'b1; redirect_pc = 32'h102; #1;
    nv++; if (bus.req !== 1'b0) begin nf++; $display("FAIL rdw_req_redirect got %b want 0", bus.req); end
    cyc; redirect = 1'b0; #1;
    nv++; if ({bus.req, inst_valid} !== 2'b00) begin nf++; $display("FAIL rdw_drop got req=%b valid=%b want 0/0", bus.req, inst_valid); end
    cyc; #1;
    nv++; if ({bus.req, inst_valid} !== 2'b00) begin nf++; $display("FAIL rdw_stale got req=%b valid=%b want 0/0", bus.req, inst_valid); end
    cyc; #1;
    nv++; if ({bus.req, bus.addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin nf++; $display("FAIL rdw_refetch got %b/%h valid=%b want 1/00000100 valid=0", bus.req, bus.addr, inst_valid); end
    cyc; cyc; cyc; #1;
    nv++; if (inst_valid !== 1'b0) begin nf++; $display("FAIL rdw_pending got %b want 0", inst_valid); end
    cyc; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h100, 32'hC0DE_0100}) begin nf++; $display("FAIL rdw_buf got %b/%h/%h want 1/00000100/c0de0100", inst_valid, pc_out, inst_out); end
  endtask
  task test_redirect_rvalid;
    lat = 1;
    do_reset;
    cyc; cyc;
    redirect = 1'b1; redirect_pc = 32'h200; #1;
    nv++; if (bus.req !== 1'b0) begin nf++; $display("FAIL rdr_req got %b want 0", bus.req); end
    cyc; redirect = 1'b0; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== 65'd0) begin nf++; $display("FAIL rdr_discard got %b/%h/%h want 0/00000000/00000000", inst_valid, pc_out, inst_out); end
    nv++; if ({bus.req, bus.addr} !== {1'b1, 32'h200}) begin nf++; $display("FAIL rdr_refetch got %b/%h want 1/00000200", bus.req, bus.addr); end
    cyc; cyc; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h200, 32'hC0DE_0200}) begin nf++; $display("FAIL rdr_buf got %b/%h/%h want 1/00000200/c0de0200", inst_valid, pc_out, inst_out); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; #1;
    nv++; if (bus.req !== 1'b0) begin nf++; $display("FAIL rds_req got %b want 0", bus.req); end
    cyc; redirect = 1'b0; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== 65'd0) begin nf++; $display("FAIL rds_flush got %b/%h/%h want 0/00000000/00000000", inst_valid, pc_out, inst_out); end
    nv++; if ({bus.req, bus.addr} !== {1'b1, 32'h300}) begin nf++; $display("FAIL rds_refetch got %b/%h want 1/00000300", bus.req, bus.addr); end
    stall = 1'b0;
  endtask
  task test_wrap;
    lat = 1;
    do_reset;
    cyc;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    nv++; if (bus.req !== 1'b0) begin nf++; $display("FAIL wrap_redirect_req got %b want 0", bus.req); end
    cyc; redirect = 1'b0; #1;
    nv++; if ({bus.req, bus.addr} !== {1'b1, 32'hFFFF_FFFC}) begin nf++; $display("FAIL wrap_req_top got %b/%h want 1/fffffffc", bus.req, bus.addr); end
    cyc; cyc; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC}) begin nf++; $display("FAIL wrap_buf_top got %b/%h/%h want 1/fffffffc/3f21fffc", inst_valid, pc_out, inst_out); end
    nv++; if ({bus.req, bus.addr} !== {1'b1, 32'h0}) begin nf++; $display("FAIL wrap_req_zero got %b/%h want 1/00000000", bus.req, bus.addr); end
    cyc; cyc; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h0, 32'hC0DE_0000}) begin nf++; $display("FAIL wrap_buf_zero got %b/%h/%h want 1/00000000/c0de0000", inst_valid, pc_out, inst_out); end
  endtask
  task test_reset_mid_wait;
    lat = 2;
    do_reset;
    cyc; cyc;
    reset = 1'b1;
    cyc; reset = 1'b0; #1;
    nv++; if ({bus.req, inst_valid} !== 2'b00) begin nf++; $display("FAIL rmw_idle got req=%b valid=%b want 0/0", bus.req, inst_valid); end
    cyc; #1;
    nv++; if ({bus.req, bus.addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin nf++; $display("FAIL rmw_refetch got %b/%h valid=%b want 1/00000000 valid=0", bus.req, bus.addr, inst_valid); end
    cyc; #1;
    nv++; if (inst_valid !== 1'b0) begin nf++; $display("FAIL rmw_wait got %b want 0", inst_valid); end
    cyc; cyc; #1;
    nv++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h0, 32'hC0DE_0000}) begin nf++; $display("FAIL rmw_buf got %b/%h/%h want 1/00000000/c0de0000", inst_valid, pc_out, inst_out); end
  endtask
  initial begin
    test_reset;
    test_fetch;
    test_stall;
    test_redirect_wait;
    test_redirect_rvalid;
    test_wrap;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
